// File: rtl/elevator_pkg.sv
// Shared types for the elevator button path: key codes, keypad scanner states, matrix geometry
// and the row priority encoder used by keypad_scanner.
package elevator_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [3:0] {
    STOP   = 4'hA,
    RESUME = 4'hB,
    UP     = 4'hC,
    DOWN   = 4'hD,
    ESCAPE = 4'hE,
    ENTER  = 4'hF
  } button_e;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    HELD
  } scan_state_e;

  // Key code {row, col}; when several rows are down the highest row wins.
  function automatic logic [3:0] encode_key(input logic [3:0] rs, input logic [1:0] col);
    logic [1:0] row;
    row = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rs[r]) row = 2'(r);
    end
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; reset value is selectable so
// pulled-up lines come out of reset in their idle state.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, debounce, one priority-encoded strobe per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat of the UP/DOWN codes while held.
module keypad_scanner
  import elevator_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_RATE     = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] buttonBus,
  output logic       pressed
);

  localparam int DW_W = $clog2(SCAN_DIV + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 2 || REPEAT_DELAY < REPEAT_RATE)
  begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0] rows_sync;
  logic [3:0] rs;
  logic [3:0] rs_code;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rows),
    .q   (rows_sync)
  );

  assign rs = ~rows_sync;

  scan_state_e     state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] run_q, run_d;
  logic [3:0]      code_q, code_d;
  logic [3:0]      cols_q, cols_d;
  logic [3:0]      bus_q, bus_d;
  logic            pressed_q, pressed_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  logic [HOLD_W-1:0] hold_q, hold_d, hold_tgt;
  logic              rep_q, rep_d;

  // The counter clears on the EMIT cycle, so the next pulse lands exactly tgt+2 cycles later.
  assign hold_tgt = rep_q ? HOLD_W'(REPEAT_RATE - 2) : HOLD_W'(REPEAT_DELAY - 2);
`endif

  assign rs_code = encode_key(rs, col_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    run_d     = run_q;
    code_d    = code_q;
    pressed_d = 1'b0;
    bus_d     = 4'h0;
`ifdef KEYPAD_REPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else if (rs != 4'h0) begin
          code_d  = rs_code;
          run_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end
      end
      DEBOUNCE: begin
        if (rs == 4'h0 || rs_code != code_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (run_q == DB_LAST) begin
          state_d   = EMIT;
          pressed_d = 1'b1;
          bus_d     = code_q;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      EMIT: begin
        state_d = HELD;
        run_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        hold_d  = '0;
`endif
      end
      HELD: begin
        if (rs == 4'h0) begin
          if (run_q == DB_LAST) begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            dwell_d = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
`ifdef KEYPAD_REPEAT_EN
          hold_d = '0;
          rep_d  = 1'b0;
`endif
        end else begin
          run_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if ((code_q == UP || code_q == DOWN) && hold_q == hold_tgt) begin
            state_d   = EMIT;
            pressed_d = 1'b1;
            bus_d     = code_q;
            rep_d     = 1'b1;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
    cols_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      run_q     <= '0;
      code_q    <= 4'h0;
      cols_q    <= 4'b1110;
      bus_q     <= 4'h0;
      pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_q    <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      run_q     <= run_d;
      code_q    <= code_d;
      cols_q    <= cols_d;
      bus_q     <= bus_d;
      pressed_q <= pressed_d;
`ifdef KEYPAD_REPEAT_EN
      hold_q    <= hold_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign cols      = cols_q;
  assign buttonBus = bus_q;
  assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, behavioural scanner reference and
// directed plus randomized key sequences.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 5;
  localparam int RD       = 120;
  localparam int RR       = 40;

  localparam int PH_LOOK    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_FIRE    = 2;
  localparam int PH_HOLD    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  buttonBus;
  logic        pressed;
  logic [15:0] keys = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  int dut_pulses = 0;
  int dut_codes[$];

  // reference model state
  logic [3:0] m_s1, m_s2;
  int m_phase, m_col, m_dwell, m_code, m_streak;
  int m_step, m_latch_step, m_last_lat, m_anchor, m_pulses;
  bit m_repeated;
  bit m_press;
  int m_bus;

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .buttonBus (buttonBus),
    .pressed   (pressed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int top_row(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_phase = PH_LOOK; m_col = 0; m_dwell = 0; m_code = 0; m_streak = 0;
    m_press = 1'b0; m_bus = 0; m_anchor = 0; m_repeated = 1'b0;
  endtask

  task automatic model_fire();
    m_phase = PH_FIRE;
    m_press = 1'b1;
    m_bus   = m_code;
    m_pulses++;
    m_last_lat = m_step - m_latch_step + 1;
  endtask

  task automatic model_rescan();
    m_phase = PH_LOOK;
    m_col   = (m_col + 1) % 4;
    m_dwell = 0;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    int hit;
    rs = ~m_s2;
    m_s2 = m_s1;
    m_s1 = rows;
    m_step++;
    m_press = 1'b0;
    m_bus = 0;
    hit = (rs != 4'h0) ? 4 * top_row(rs) + m_col : -1;
    case (m_phase)
      PH_LOOK: begin
        if (m_dwell < SCAN_DIV - 1) m_dwell++;
        else if (hit >= 0) begin
          m_code = hit; m_streak = 0; m_phase = PH_CONFIRM; m_latch_step = m_step;
        end else model_rescan();
      end
      PH_CONFIRM: begin
        if (hit != m_code) model_rescan();
        else begin
          m_streak++;
          if (m_streak == DEB) model_fire();
        end
      end
      PH_FIRE: begin
        m_phase = PH_HOLD; m_streak = 0; m_anchor = m_step;
      end
      default: begin
        if (hit < 0) begin
          m_streak++;
          m_anchor = m_step;
          m_repeated = 1'b0;
          if (m_streak == DEB) model_rescan();
        end else begin
          m_streak = 0;
`ifdef KEYPAD_REPEAT_EN
          if ((m_code == 12 || m_code == 13) &&
              (m_step - m_anchor == (m_repeated ? RR : RD) - 1)) begin
            model_fire();
            m_repeated = 1'b1;
          end
`endif
        end
      end
    endcase
  endtask

  initial begin
    m_step = 0; m_pulses = 0; m_latch_step = 0; m_last_lat = 0;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (armed && !rst) begin
        check("cols", cols, 4'(~(4'b0001 << m_col)));
        check("pressed", pressed, m_press);
        check("buttonBus", buttonBus, m_bus);
        if (pressed === 1'b1) begin
          dut_pulses++;
          dut_codes.push_back(int'(buttonBus));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_key(input int code, input int n_down, input int n_up);
    keys = 16'(1) << code;
    idle(n_down);
    keys = '0;
    idle(n_up);
  endtask

  initial begin
    int p0;
    int hk;
    #1 rst = 1'b1;
    idle(3);
    check("reset_cols", cols, 4'b1110);
    check("reset_pressed", pressed, 1'b0);
    check("reset_bus", buttonBus, 4'h0);
    rst = 1'b0;
    armed = 1'b1;

    // row1/col1 held
    p0 = dut_pulses;
    hold_key(5, 100, 3 * DEB + 10);
    check("t1_pulses", dut_pulses - p0, 1);
    check("t1_code", dut_codes[$], 4'h5);
    check("t1_latency", m_last_lat, DEB + 1);

    // bouncing 0xB never stable long enough
    p0 = dut_pulses;
    for (int i = 0; i < 20; i++) hold_key(11, 5, 3);
    idle(20);
    check("t2_pulses", dut_pulses - p0, 0);

    // two rows on col2: highest row (3) wins -> 0xE
    p0 = dut_pulses;
    keys = 16'h4004;
    idle(80);
    keys = '0;
    idle(3 * DEB + 10);
    check("t3_pulses", dut_pulses - p0, 1);
    check("t3_code", dut_codes[$], 4'hE);

    // long holds of UP and ENTER
    p0 = dut_pulses;
    hold_key(12, 3 * RD, 3 * DEB + 10);
`ifndef KEYPAD_REPEAT_EN
    check("t4_up_pulses", dut_pulses - p0, 1);
`endif
    check("t4_up_code", dut_codes[$], 4'hC);
    p0 = dut_pulses;
    hold_key(15, 3 * RD, 3 * DEB + 10);
    check("t4_enter_pulses", dut_pulses - p0, 1);
    check("t4_enter_code", dut_codes[$], 4'hF);

    // reset during debounce
    keys = 16'(1) << 5;
    for (int i = 0; i < 200 && m_phase != PH_CONFIRM; i++) @(negedge clk);
    check("t5_debounce_reached", m_phase, PH_CONFIRM);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_cols", cols, 4'b1110);
    check("t5_rst_pressed", pressed, 1'b0);
    check("t5_rst_bus", buttonBus, 4'h0);
    p0 = dut_pulses;
    @(negedge clk);
    rst = 1'b0;
    idle(SCAN_DIV + DEB);
    check("t5_no_early_pulse", dut_pulses - p0, 0);
    idle(60);
    keys = '0;
    idle(3 * DEB + 10);
    check("t5_fresh_pulse", dut_pulses - p0, 1);
    check("t5_code", dut_codes[$], 4'h5);

    // 0x3, release, 0xA
    p0 = dut_pulses;
    hold_key(3, 60, 3 * DEB);
    hold_key(10, 60, 3 * DEB + 10);
    check("t6_pulses", dut_pulses - p0, 2);
    check("t6_first", dut_codes[dut_codes.size()-2], 4'h3);
    check("t6_second", dut_codes[$], 4'hA);

    // random presses, sometimes two keys at once, random durations
    for (int i = 0; i < 60; i++) begin
      hk = $urandom_range(0, 15);
      keys = 16'(1) << hk;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      idle($urandom_range(1, 80));
      keys = '0;
      idle($urandom_range(0, 40));
    end
    idle(3 * DEB + 10);
    check("total_pulses", dut_pulses, m_pulses);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
